// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Purpose:
//   Sequences the data-memory access of the instruction in the MEM stage.
//   A load or store raises a req/ack transaction toward a variable-latency
//   data memory. The upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) is frozen
//   until the access completes or times out. The controller also qualifies
//   what enters the MEM/WB register: readData and the WB (RegWrite) control.
//   A timed-out access becomes a bubble (WB suppressed) and raises a sticky
//   error. Non-memory instructions pass through with zero added latency.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   ex_memRead     MEM-stage instruction is a load
//   ex_memWrite    MEM-stage instruction is a store
//   ex_WB          RegWrite control of the MEM-stage instruction
//   ex_address     memory address (ALU result)
//   ex_writeData   store data
//   mem_req        memory request, held until ack or abort
//   mem_we         1 = write, 0 = read; valid while mem_req is high
//   mem_addr       latched address (held between transactions)
//   mem_wdata      latched store data (held between transactions)
//   mem_ack        one-cycle completion pulse from memory
//   mem_rdata      read data, valid with mem_ack
//   stall          freezes upstream pipeline registers (combinational)
//   wb_valid       WB control into MEM/WB (combinational)
//   wb_readData    readData into MEM/WB (registered)
//   mem_err        sticky error: timeout or simultaneous read+write
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15   // WAIT cycles without ack before abort, 1..255
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              ex_memRead,
  input  logic              ex_memWrite,
  input  logic              ex_WB,
  input  logic [ADDR_W-1:0] ex_address,
  input  logic [DATA_W-1:0] ex_writeData,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_readData,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Last WAIT-cycle count before the access is abandoned. TIMEOUT is capped
  // at 255 so the 8-bit counter never wraps.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e              state_q,     state_d;
  logic [7:0]          cnt_q,       cnt_d;
  logic                abort_q,     abort_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q,     rdata_d;
  logic                mem_err_q,   mem_err_d;

  logic                stall_c;
  logic                wb_valid_c;
  logic                access;

  assign access = ex_memRead | ex_memWrite;

  // ---------------------------------------------------------------------------
  // Next-state and combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    mem_err_d   = mem_err_q;
    stall_c     = 1'b0;
    wb_valid_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        rdata_d = '0;
        if (access) begin
          // Freeze the pipeline in the detection cycle itself, so the
          // instruction is still in EX/MEM when the address is latched.
          stall_c     = 1'b1;
          mem_addr_d  = ex_address;
          mem_wdata_d = ex_writeData;
          // A simultaneous read+write resolves as a write and is flagged.
          mem_we_d    = ex_memWrite;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT;
          if (ex_memRead && ex_memWrite) begin
            mem_err_d = 1'b1;
          end
        end else begin
          wb_valid_c = ex_WB;
        end
      end

      WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        // Ack is checked first so that an ack in the expiry cycle still
        // completes the access normally.
        if (mem_ack) begin
          rdata_d   = mem_we_q ? '0 : mem_rdata;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d   = '0;
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
          abort_d   = 1'b1;
          state_d   = DONE;
        end
      end

      DONE: begin
        // The pipeline advances at the end of this cycle; an aborted access
        // enters MEM/WB as a bubble. wb_readData stays visible for this
        // cycle and is cleared on the way back to IDLE.
        wb_valid_c = ex_WB & ~abort_q;
        abort_d    = 1'b0;
        rdata_d    = '0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The combinational controls are gated by rst_n so that, while reset is
  // held, the pipeline is neither frozen nor writing back.
  assign stall       = stall_c    & rst_n;
  assign wb_valid    = wb_valid_c & rst_n;

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_readData = rdata_q;
  assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed testbench for mem_access_ctrl. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled on the falling edge. Each task covers
// one scenario and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ex_memRead;
  logic              ex_memWrite;
  logic              ex_WB;
  logic [ADDR_W-1:0] ex_address;
  logic [DATA_W-1:0] ex_writeData;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_readData;
  logic              mem_err;

  int checks   = 0;
  int failures = 0;

  mem_access_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_memRead  (ex_memRead),
    .ex_memWrite (ex_memWrite),
    .ex_WB       (ex_WB),
    .ex_address  (ex_address),
    .ex_writeData(ex_writeData),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_readData (wb_readData),
    .mem_err     (mem_err)
  );

  always #5 clk = ~clk;

  // Start of a new cycle: just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample point for the current cycle.
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ex_memRead   = 1'b0;
    ex_memWrite  = 1'b0;
    ex_WB        = 1'b0;
    ex_address   = '0;
    ex_writeData = '0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    idle_inputs();
    cyc();
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    ex_memRead = 1'b1;  // must not stall or write back while in reset
    ex_WB      = 1'b1;
    smp();
    checks++;
    if ({stall, wb_valid, mem_req, mem_we, mem_err} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_ctrl: got stall/wbv/req/we/err=%b exp 00000",
               {stall, wb_valid, mem_req, mem_we, mem_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, wb_readData} !== 96'd0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h exp all 0",
               mem_addr, mem_wdata, wb_readData);
    end
    cyc();
    rst_n = 1'b1;
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_alu_passthrough();
    cyc();
    ex_WB = 1'b1;
    smp();
    checks++;
    if ({stall, wb_valid, mem_req} !== 3'b010 || wb_readData !== '0) begin
      failures++;
      $display("FAIL alu_pass: got stall/wbv/req=%b rdata=%h exp 010 rdata=0",
               {stall, wb_valid, mem_req}, wb_readData);
    end
    cyc();
    ex_WB = 1'b0;
    smp();
    checks++;
    if ({stall, wb_valid, mem_req} !== 3'b000) begin
      failures++;
      $display("FAIL alu_pass_wb0: got stall/wbv/req=%b exp 000",
               {stall, wb_valid, mem_req});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Load 0x40, ack in the second WAIT cycle: stall 3 cycles, req 2 cycles.
  task automatic test_load();
    cyc();
    ex_memRead = 1'b1;
    ex_WB      = 1'b1;
    ex_address = 32'h0000_0040;
    smp();
    checks++;
    if ({stall, wb_valid, mem_req} !== 3'b100) begin
      failures++;
      $display("FAIL load_detect: got stall/wbv/req=%b exp 100",
               {stall, wb_valid, mem_req});
    end
    cyc();  // WAIT 1
    smp();
    checks++;
    if ({stall, wb_valid, mem_req, mem_we} !== 4'b1010 || mem_addr !== 32'h40) begin
      failures++;
      $display("FAIL load_wait1: got stall/wbv/req/we=%b addr=%h exp 1010 addr=00000040",
               {stall, wb_valid, mem_req, mem_we}, mem_addr);
    end
    cyc();  // WAIT 2, ack arrives
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    smp();
    checks++;
    if ({stall, wb_valid, mem_req} !== 3'b101) begin
      failures++;
      $display("FAIL load_wait2: got stall/wbv/req=%b exp 101",
               {stall, wb_valid, mem_req});
    end
    cyc();  // DONE
    mem_ack   = 1'b0;
    mem_rdata = '0;
    smp();
    checks++;
    if ({stall, wb_valid, mem_req} !== 3'b010 || wb_readData !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL load_done: got stall/wbv/req=%b rdata=%h exp 010 rdata=deadbeef",
               {stall, wb_valid, mem_req}, wb_readData);
    end
    cyc();  // IDLE again, pipeline advanced
    idle_inputs();
    smp();
    checks++;
    if ({stall, mem_req, mem_err} !== 3'b000 || wb_readData !== '0 ||
        mem_addr !== 32'h40) begin
      failures++;
      $display("FAIL load_after: got stall/req/err=%b rdata=%h addr=%h exp 000 0 00000040",
               {stall, mem_req, mem_err}, wb_readData, mem_addr);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Store 0x12345678 to 0x100, ack in first WAIT cycle, ex_WB=0.
  task automatic test_store();
    cyc();
    ex_memWrite  = 1'b1;
    ex_address   = 32'h0000_0100;
    ex_writeData = 32'h1234_5678;
    smp();
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL store_detect: got stall=%b exp 1", stall);
    end
    cyc();  // WAIT 1 with ack; rdata on the bus must be ignored for a store
    mem_ack   = 1'b1;
    mem_rdata = 32'hAAAA_5555;
    smp();
    checks++;
    if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h100 ||
        mem_wdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL store_wait: got req/we=%b addr=%h wdata=%h exp 11 00000100 12345678",
               {mem_req, mem_we}, mem_addr, mem_wdata);
    end
    cyc();  // DONE
    mem_ack   = 1'b0;
    mem_rdata = '0;
    smp();
    checks++;
    if ({stall, wb_valid, mem_req} !== 3'b000 || wb_readData !== '0) begin
      failures++;
      $display("FAIL store_done: got stall/wbv/req=%b rdata=%h exp 000 0",
               {stall, wb_valid, mem_req}, wb_readData);
    end
    cyc();  // IDLE with a stray ack: ignored
    idle_inputs();
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    cyc();
    mem_ack = 1'b0;
    smp();
    checks++;
    if ({stall, mem_req, mem_we} !== 3'b001 || wb_readData !== '0 ||
        mem_wdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL stray_ack_idle: got stall/req/we=%b rdata=%h wdata=%h exp 001 0 12345678",
               {stall, mem_req, mem_we}, wb_readData, mem_wdata);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Load with no ack: exactly TIMEOUT WAIT cycles, then a bubble and error.
  task automatic test_timeout();
    cyc();
    ex_memRead = 1'b1;
    ex_WB      = 1'b1;
    ex_address = 32'h0000_0080;
    for (int i = 0; i < TIMEOUT; i++) begin
      cyc();
      smp();
      checks++;
      if ({stall, mem_req, mem_err} !== 3'b110) begin
        failures++;
        $display("FAIL timeout_wait%0d: got stall/req/err=%b exp 110",
                 i, {stall, mem_req, mem_err});
      end
    end
    cyc();  // DONE (aborted)
    smp();
    checks++;
    if ({stall, wb_valid, mem_req, mem_err} !== 4'b0001 || wb_readData !== '0) begin
      failures++;
      $display("FAIL timeout_done: got stall/wbv/req/err=%b rdata=%h exp 0001 0",
               {stall, wb_valid, mem_req, mem_err}, wb_readData);
    end
    cyc();  // next instruction is an ALU op with WB
    idle_inputs();
    ex_WB = 1'b1;
    smp();
    checks++;
    if ({stall, wb_valid, mem_req, mem_err} !== 4'b0101) begin
      failures++;
      $display("FAIL timeout_after: got stall/wbv/req/err=%b exp 0101",
               {stall, wb_valid, mem_req, mem_err});
    end
    cyc();
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Ack in the final WAIT cycle wins over the timeout.
  task automatic test_ack_at_timeout();
    do_reset();
    cyc();
    ex_memRead = 1'b1;
    ex_WB      = 1'b1;
    ex_address = 32'h0000_00C0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      cyc();
    end
    cyc();  // WAIT cycle TIMEOUT, ack arrives now
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    smp();
    checks++;
    if ({stall, mem_req} !== 2'b11) begin
      failures++;
      $display("FAIL ack_tmo_wait: got stall/req=%b exp 11", {stall, mem_req});
    end
    cyc();  // DONE
    mem_ack   = 1'b0;
    mem_rdata = '0;
    smp();
    checks++;
    if ({stall, wb_valid, mem_req, mem_err} !== 4'b0100 ||
        wb_readData !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL ack_tmo_done: got stall/wbv/req/err=%b rdata=%h exp 0100 cafef00d",
               {stall, wb_valid, mem_req, mem_err}, wb_readData);
    end
    cyc();
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Two loads back to back: the second is detected in the IDLE cycle after
  // DONE and gets its own request.
  task automatic test_back_to_back();
    cyc();
    ex_memRead = 1'b1;
    ex_WB      = 1'b1;
    ex_address = 32'h0000_0200;
    cyc();  // WAIT A with ack
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_1111;
    cyc();  // DONE A
    mem_ack = 1'b0;
    smp();
    checks++;
    if ({stall, wb_valid, mem_req} !== 3'b010 || wb_readData !== 32'h1111_1111) begin
      failures++;
      $display("FAIL b2b_doneA: got stall/wbv/req=%b rdata=%h exp 010 11111111",
               {stall, wb_valid, mem_req}, wb_readData);
    end
    cyc();  // IDLE, load B presented
    ex_address = 32'h0000_0204;
    smp();
    checks++;
    if ({stall, wb_valid, mem_req} !== 3'b100 || mem_addr !== 32'h200) begin
      failures++;
      $display("FAIL b2b_idle: got stall/wbv/req=%b addr=%h exp 100 00000200",
               {stall, wb_valid, mem_req}, mem_addr);
    end
    cyc();  // WAIT B with ack
    mem_ack   = 1'b1;
    mem_rdata = 32'h2222_2222;
    smp();
    checks++;
    if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h204) begin
      failures++;
      $display("FAIL b2b_waitB: got req/we=%b addr=%h exp 10 00000204",
               {mem_req, mem_we}, mem_addr);
    end
    cyc();  // DONE B
    mem_ack = 1'b0;
    smp();
    checks++;
    if ({stall, wb_valid, mem_req} !== 3'b010 || wb_readData !== 32'h2222_2222) begin
      failures++;
      $display("FAIL b2b_doneB: got stall/wbv/req=%b rdata=%h exp 010 22222222",
               {stall, wb_valid, mem_req}, wb_readData);
    end
    cyc();
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Read and write together: treated as a write, error raised.
  task automatic test_read_write_conflict();
    do_reset();
    cyc();
    ex_memRead   = 1'b1;
    ex_memWrite  = 1'b1;
    ex_address   = 32'h0000_0300;
    ex_writeData = 32'h0BAD_0BAD;
    cyc();  // WAIT
    smp();
    checks++;
    if ({mem_req, mem_we, mem_err} !== 3'b111 || mem_wdata !== 32'h0BAD_0BAD) begin
      failures++;
      $display("FAIL rw_conflict: got req/we/err=%b wdata=%h exp 111 0bad0bad",
               {mem_req, mem_we, mem_err}, mem_wdata);
    end
    mem_ack = 1'b1;
    cyc();  // (ack was sampled at the edge) DONE
    mem_ack = 1'b0;
    cyc();
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Reset asserted mid-WAIT aborts immediately; a later stray ack is ignored.
  task automatic test_reset_mid_wait();
    cyc();
    ex_memRead = 1'b1;
    ex_WB      = 1'b1;
    ex_address = 32'h0000_0400;
    cyc();  // WAIT 1
    smp();
    checks++;
    if ({stall, mem_req, mem_err} !== 3'b111) begin
      failures++;
      $display("FAIL rst_mid_pre: got stall/req/err=%b exp 111",
               {stall, mem_req, mem_err});
    end
    cyc();  // WAIT 2, reset asserted mid-cycle
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, wb_valid, mem_req, mem_err} !== 4'b0000 || mem_addr !== '0) begin
      failures++;
      $display("FAIL rst_mid_async: got stall/wbv/req/err=%b addr=%h exp 0000 0",
               {stall, wb_valid, mem_req, mem_err}, mem_addr);
    end
    cyc();
    rst_n      = 1'b1;
    ex_memRead = 1'b0;
    mem_ack    = 1'b1;
    mem_rdata  = 32'h7777_7777;
    smp();
    checks++;
    if ({stall, wb_valid, mem_req, mem_err} !== 4'b0100 || wb_readData !== '0) begin
      failures++;
      $display("FAIL rst_mid_idle: got stall/wbv/req/err=%b rdata=%h exp 0100 0",
               {stall, wb_valid, mem_req, mem_err}, wb_readData);
    end
    cyc();
    mem_ack = 1'b0;
    smp();
    checks++;
    if ({stall, mem_req, mem_err} !== 3'b000 || wb_readData !== '0) begin
      failures++;
      $display("FAIL rst_mid_stray: got stall/req/err=%b rdata=%h exp 000 0",
               {stall, mem_req, mem_err}, wb_readData);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_alu_passthrough();
    test_load();
    test_store();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_read_write_conflict();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
